// File: rtl/control_sequencer.sv
// Fetch-decode-execute control unit for the Mini-CPU: sequences fetch and drives all bus enables/load strobes.
// Optional CU_ILLEGAL_TRAP_EN: undefined opcodes halt and raise 'illegal' instead of executing as NOP.
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic       zero_flag,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_in,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_we,
    output logic       cir_in,
    output logic       cir_out,
    output logic       acc_in,
    output logic       acc_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       alu_sub,
    output logic       flags_in,
    output logic       halted,
`ifdef CU_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_F0   = 3'd0,
        S_F1   = 3'd1,
        S_DEC  = 3'd2,
        S_E0   = 3'd3,
        S_E1   = 3'd4,
        S_E2   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t r_state;

    logic w_isNop;
    logic w_isHlt;
    logic w_isExec;
    logic w_isMem;
    logic w_isAlu;

    assign w_isNop  = (opcode == 8'h00);
    assign w_isHlt  = (opcode == 8'hFF);
    assign w_isExec = (opcode[7:3] == 5'd0) && !w_isNop;
    assign w_isMem  = (opcode == 8'h02) || (opcode == 8'h03);
    assign w_isAlu  = (opcode == 8'h04) || (opcode == 8'h05);

`ifdef CU_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign illegal = r_illegal;
`endif

    // Opcode is only trusted from DEC onward; the execute length is chosen from it step by step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_F0;
`ifdef CU_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_F0:  r_state <= S_F1;
                S_F1:  r_state <= S_DEC;
                S_DEC: begin
                    if (w_isHlt)
                        r_state <= S_HALT;
                    else if (w_isExec)
                        r_state <= S_E0;
                    else if (w_isNop)
                        r_state <= S_F0;
                    else begin
`ifdef CU_ILLEGAL_TRAP_EN
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
`else
                        r_state   <= S_F0;
`endif
                    end
                end
                S_E0:   r_state <= (w_isMem || w_isAlu) ? S_E1 : S_F0;
                S_E1:   r_state <= w_isAlu ? S_E2 : S_F0;
                S_E2:   r_state <= S_F0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_F0;
            endcase
        end
    end

    // Strobes are decoded combinationally; only one bus driver is ever selected per state/opcode.
    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_in    = 1'b0;
        mar_in   = 1'b0;
        ram_out  = 1'b0;
        ram_we   = 1'b0;
        cir_in   = 1'b0;
        cir_out  = 1'b0;
        acc_in   = 1'b0;
        acc_out  = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        alu_sub  = 1'b0;
        flags_in = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_F0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
            end
            S_F1: begin
                ram_out = 1'b1;
                cir_in  = 1'b1;
                pc_inc  = 1'b1;
            end
            S_E0: begin
                case (opcode)
                    8'h01: begin
                        cir_out = 1'b1;
                        acc_in  = 1'b1;
                    end
                    8'h02, 8'h03, 8'h04, 8'h05: begin
                        cir_out = 1'b1;
                        mar_in  = 1'b1;
                    end
                    8'h06: begin
                        cir_out = 1'b1;
                        pc_in   = 1'b1;
                    end
                    8'h07: begin
                        cir_out = zero_flag;
                        pc_in   = zero_flag;
                    end
                    default: ;
                endcase
            end
            S_E1: begin
                case (opcode)
                    8'h02: begin
                        ram_out = 1'b1;
                        acc_in  = 1'b1;
                    end
                    8'h03: begin
                        acc_out = 1'b1;
                        ram_we  = 1'b1;
                    end
                    8'h04, 8'h05: begin
                        ram_out = 1'b1;
                        b_in    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E2: begin
                if (w_isAlu) begin
                    alu_out  = 1'b1;
                    acc_in   = 1'b1;
                    flags_in = 1'b1;
                    alu_sub  = (opcode == 8'h05);
                end
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign state = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a driver pushes per-cycle expectations from an opcode table, a monitor checks them.
// Build with CU_ILLEGAL_TRAP_EN defined to exercise the illegal-opcode trap.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] opcode;
    logic       zero_flag;
    logic       pc_out, pc_inc, pc_in, mar_in, ram_out, ram_we, cir_in, cir_out;
    logic       acc_in, acc_out, b_in, alu_out, alu_sub, flags_in, halted;
    logic [2:0] state;
`ifdef CU_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] M_PC_OUT   = 15'h4000;
    localparam logic [14:0] M_PC_INC   = 15'h2000;
    localparam logic [14:0] M_PC_IN    = 15'h1000;
    localparam logic [14:0] M_MAR_IN   = 15'h0800;
    localparam logic [14:0] M_RAM_OUT  = 15'h0400;
    localparam logic [14:0] M_RAM_WE   = 15'h0200;
    localparam logic [14:0] M_CIR_IN   = 15'h0100;
    localparam logic [14:0] M_CIR_OUT  = 15'h0080;
    localparam logic [14:0] M_ACC_IN   = 15'h0040;
    localparam logic [14:0] M_ACC_OUT  = 15'h0020;
    localparam logic [14:0] M_B_IN     = 15'h0010;
    localparam logic [14:0] M_ALU_OUT  = 15'h0008;
    localparam logic [14:0] M_ALU_SUB  = 15'h0004;
    localparam logic [14:0] M_FLAGS_IN = 15'h0002;
    localparam logic [14:0] M_HALTED   = 15'h0001;

    typedef struct {
        logic [2:0]  st;
        logic [14:0] sig;
        logic        ill;
        logic [7:0]  op;
        int          step;
    } rec_t;

    rec_t expQ[$];
    rec_t plan[$];

    control_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero_flag (zero_flag),
        .pc_out    (pc_out),
        .pc_inc    (pc_inc),
        .pc_in     (pc_in),
        .mar_in    (mar_in),
        .ram_out   (ram_out),
        .ram_we    (ram_we),
        .cir_in    (cir_in),
        .cir_out   (cir_out),
        .acc_in    (acc_in),
        .acc_out   (acc_out),
        .b_in      (b_in),
        .alu_out   (alu_out),
        .alu_sub   (alu_sub),
        .flags_in  (flags_in),
        .halted    (halted),
`ifdef CU_ILLEGAL_TRAP_EN
        .illegal   (illegal),
`endif
        .state     (state)
    );

    always #5 clk = ~clk;

    // Reference model: whole-instruction cycle list built from the instruction table.
    task automatic fillPlan(input logic [7:0] op, input bit zf, input int haltLen);
        logic [14:0] ex[$];
        bit defined;
        bit halts;
        bit trapIll;
        plan.delete();
        defined = (op <= 8'h07) || (op == 8'hFF);
        trapIll = 1'b0;
        halts   = (op == 8'hFF);
`ifdef CU_ILLEGAL_TRAP_EN
        if (!defined) begin
            halts   = 1'b1;
            trapIll = 1'b1;
        end
`endif
        case (op)
            8'h01: ex.push_back(M_CIR_OUT | M_ACC_IN);
            8'h02: begin
                ex.push_back(M_CIR_OUT | M_MAR_IN);
                ex.push_back(M_RAM_OUT | M_ACC_IN);
            end
            8'h03: begin
                ex.push_back(M_CIR_OUT | M_MAR_IN);
                ex.push_back(M_ACC_OUT | M_RAM_WE);
            end
            8'h04, 8'h05: begin
                ex.push_back(M_CIR_OUT | M_MAR_IN);
                ex.push_back(M_RAM_OUT | M_B_IN);
                ex.push_back(M_ALU_OUT | M_ACC_IN | M_FLAGS_IN | ((op == 8'h05) ? M_ALU_SUB : 15'h0));
            end
            8'h06: ex.push_back(M_CIR_OUT | M_PC_IN);
            8'h07: ex.push_back(zf ? (M_CIR_OUT | M_PC_IN) : 15'h0);
            default: ;
        endcase
        plan.push_back('{st: 3'd0, sig: M_PC_OUT | M_MAR_IN, ill: 1'b0, op: op, step: 0});
        plan.push_back('{st: 3'd1, sig: M_RAM_OUT | M_CIR_IN | M_PC_INC, ill: 1'b0, op: op, step: 1});
        plan.push_back('{st: 3'd2, sig: 15'h0, ill: 1'b0, op: op, step: 2});
        if (halts) begin
            for (int i = 0; i < haltLen; i++)
                plan.push_back('{st: 3'd6, sig: M_HALTED, ill: trapIll, op: op, step: 3 + i});
        end else begin
            for (int i = 0; i < ex.size(); i++)
                plan.push_back('{st: 3'(3 + i), sig: ex[i], ill: 1'b0, op: op, step: 3 + i});
        end
    endtask

    // Runs one instruction from the start of its F0 cycle; a halt or abort ends with a one-cycle reset pulse.
    task automatic applyStimulus(input logic [7:0] op, input bit zf, input int abortAt, input int haltLen);
        int n;
        int last;
        bit doReset;
        fillPlan(op, zf, haltLen);
        n = plan.size();
        doReset = (plan[n-1].st == 3'd6) || (abortAt >= 0 && abortAt < n);
        last = (abortAt >= 0 && abortAt < n) ? abortAt : n - 1;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            expQ.push_back(plan[i]);
            if (i < 2) begin
                opcode    = 8'($urandom);
                zero_flag = 1'($urandom);
            end else if (i == 2) begin
                opcode    = op;
                zero_flag = zf;
            end
        end
        if (doReset) reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic checkOutput();
        rec_t rec;
        logic [14:0] actSig;
        int busCount;
        rec = expQ.pop_front();
        actSig = {pc_out, pc_inc, pc_in, mar_in, ram_out, ram_we, cir_in, cir_out,
                  acc_in, acc_out, b_in, alu_out, alu_sub, flags_in, halted};
        checks++;
        if (state !== rec.st || actSig !== rec.sig) begin
            errors++;
            $display("[TB] FAIL op%02h step%0d: got state=%0d strobes=%h, expected state=%0d strobes=%h",
                     rec.op, rec.step, state, actSig, rec.st, rec.sig);
        end
        busCount = int'(pc_out) + int'(ram_out) + int'(cir_out) + int'(acc_out) + int'(alu_out);
        checks++;
        if (busCount > 1) begin
            errors++;
            $display("[TB] FAIL bus_contention op%02h step%0d: got %0d drivers, expected at most 1",
                     rec.op, rec.step, busCount);
        end
`ifdef CU_ILLEGAL_TRAP_EN
        checks++;
        if (illegal !== rec.ill) begin
            errors++;
            $display("[TB] FAIL illegal op%02h step%0d: got %b, expected %b", rec.op, rec.step, illegal, rec.ill);
        end
`endif
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) checkOutput();
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] op;
        int r;
        int abortAt;
        reset     = 1'b1;
        opcode    = 8'h00;
        zero_flag = 1'b0;
        @(posedge clk);
        #1;
        expQ.push_back('{st: 3'd0, sig: M_PC_OUT | M_MAR_IN, ill: 1'b0, op: 8'h00, step: 0});
        @(posedge clk);
        #1;
        reset = 1'b0;

        applyStimulus(8'h00, 1'b0, -1, 0);
        applyStimulus(8'h00, 1'b0, -1, 0);
        applyStimulus(8'h04, 1'b0, -1, 0);
        applyStimulus(8'h05, 1'b1, -1, 0);
        applyStimulus(8'h07, 1'b1, -1, 0);
        applyStimulus(8'h07, 1'b0, -1, 0);
        applyStimulus(8'h03, 1'b0, 3, 0);
        applyStimulus(8'h42, 1'b0, -1, 20);
        applyStimulus(8'h01, 1'b0, -1, 0);
        applyStimulus(8'h02, 1'b0, -1, 0);
        applyStimulus(8'h06, 1'b0, -1, 0);
        applyStimulus(8'hFF, 1'b0, -1, 20);
        applyStimulus(8'h03, 1'b1, -1, 0);

        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 11);
            if (r <= 7)
                op = 8'(r);
            else if (r == 8)
                op = 8'hFF;
            else
                op = 8'(8 + $urandom_range(0, 246));
            abortAt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : -1;
            applyStimulus(op, 1'($urandom), abortAt, $urandom_range(2, 6));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
